// File: rtl/otf_pkg.sv
// Shared types and helpers for the on-the-fly signed-digit converter.
package otf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } otf_state_e;

    // Result register width: n digits of log2_radix bits plus a sign bit.
    function automatic int unsigned result_width(input int unsigned n, input int unsigned l2r);
        return n * l2r + 1;
    endfunction

    // Legal digits lie strictly inside (-radix, radix).
    function automatic logic digit_is_legal(input int d, input int unsigned l2r);
        int lim;
        lim = int'(1 << l2r);
        return (d > -lim) && (d < lim);
    endfunction

endpackage

// File: rtl/otf_sd_converter_if.sv
// Digit-in / word-out handshake bundle; sign_valid/sign_neg exist only with OTF_EARLY_SIGN_EN.
interface otf_sd_converter_if #(
    parameter int unsigned no_of_digits = 8,
    parameter int unsigned log2_radix   = 2,
    parameter int unsigned radix_bits   = 3
);
    localparam int unsigned DOUT_W = otf_pkg::result_width(no_of_digits, log2_radix);

    logic                  din_valid;
    logic                  din_ready;
    logic [radix_bits-1:0] digit_in;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [DOUT_W-1:0]     dout;
    logic                  digit_err;
`ifdef OTF_EARLY_SIGN_EN
    logic                  sign_valid;
    logic                  sign_neg;

    modport master (output din_valid, digit_in, dout_ready,
                    input  din_ready, dout_valid, dout, digit_err, sign_valid, sign_neg);
    modport slave  (input  din_valid, digit_in, dout_ready,
                    output din_ready, dout_valid, dout, digit_err, sign_valid, sign_neg);
`else
    modport master (output din_valid, digit_in, dout_ready,
                    input  din_ready, dout_valid, dout, digit_err);
    modport slave  (input  din_valid, digit_in, dout_ready,
                    output din_ready, dout_valid, dout, digit_err);
`endif
endinterface

// File: rtl/otf_append_step.sv
// One on-the-fly append: Q/QM shifted by one digit position, low digit chosen without a carry chain.
module otf_append_step #(
    parameter int unsigned W          = 17,
    parameter int unsigned log2_radix = 2,
    parameter int unsigned radix_bits = 3
) (
    input  logic [W-1:0]                 q_i,
    input  logic [W-1:0]                 qm_i,
    input  logic signed [radix_bits-1:0] d_i,
    output logic [W-1:0]                 q_o,
    output logic [W-1:0]                 qm_o
);
    logic                  d_neg;
    logic                  d_pos;
    logic [log2_radix-1:0] d_lo;
    logic [log2_radix-1:0] dm1_lo;

    // Low digit of Q is d mod r and of QM is (d-1) mod r in every branch; only the prefix source differs.
    always_comb begin
        d_neg  = d_i[radix_bits-1];
        d_pos  = !d_neg && (d_i != '0);
        d_lo   = d_i[log2_radix-1:0];
        dm1_lo = d_lo - log2_radix'(1);
        q_o    = ((d_neg ? qm_i : q_i) << log2_radix) | W'(d_lo);
        qm_o   = ((d_pos ? q_i : qm_i) << log2_radix) | W'(dm1_lo);
    end
endmodule

// File: rtl/otf_sd_converter.sv
// On-the-fly signed-digit to two's-complement converter, MSD first.
// Optional early sign detection under `OTF_EARLY_SIGN_EN.
module otf_sd_converter
    import otf_pkg::*;
#(
    parameter int unsigned no_of_digits = 8,
    parameter int unsigned log2_radix   = 2,
    parameter int unsigned radix_bits   = 3
) (
    input logic               clk,
    input logic               rst,
    otf_sd_converter_if.slave bus
);
    localparam int unsigned W     = result_width(no_of_digits, log2_radix);
    localparam int unsigned CNT_W = $clog2(no_of_digits + 1);

    otf_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [W-1:0]       q_q, q_d, qm_q, qm_d;
    logic               digit_err_q, digit_err_d;
    logic               din_ready_q, din_ready_d;
    logic               dout_valid_q, dout_valid_d;
`ifdef OTF_EARLY_SIGN_EN
    logic               sign_valid_q, sign_valid_d;
    logic               sign_neg_q, sign_neg_d;
`endif

    logic                         accept_c;
    logic                         illegal_c;
    logic signed [radix_bits-1:0] digit_s;
    logic [CNT_W-1:0]             count_inc;
    logic [W-1:0]                 step_q_in, step_qm_in, step_q_out, step_qm_out;

    assign digit_s    = bus.digit_in;
    assign accept_c   = bus.din_valid && din_ready_q;
    assign illegal_c  = !digit_is_legal(int'(digit_s), log2_radix);
    assign count_inc  = count_q + CNT_W'(1);
    // First digit of a word sees Q=0, QM=-1 so the recurrence needs no special case.
    assign step_q_in  = (state_q == ST_IDLE) ? '0 : q_q;
    assign step_qm_in = (state_q == ST_IDLE) ? '1 : qm_q;

    otf_append_step #(
        .W          (W),
        .log2_radix (log2_radix),
        .radix_bits (radix_bits)
    ) u_step (
        .q_i  (step_q_in),
        .qm_i (step_qm_in),
        .d_i  (digit_s),
        .q_o  (step_q_out),
        .qm_o (step_qm_out)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        q_d         = q_q;
        qm_d        = qm_q;
        digit_err_d = digit_err_q;
`ifdef OTF_EARLY_SIGN_EN
        sign_valid_d = sign_valid_q;
        sign_neg_d   = sign_neg_q;
`endif

        if (accept_c) begin
            q_d  = step_q_out;
            qm_d = step_qm_out;
            if (illegal_c) digit_err_d = 1'b1;
`ifdef OTF_EARLY_SIGN_EN
            if (!sign_valid_q && (digit_s != '0)) begin
                sign_valid_d = 1'b1;
                sign_neg_d   = digit_s[radix_bits-1];
            end
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_ACC;
                    count_d = CNT_W'(1);
                end
            end
            ST_ACC: begin
                if (accept_c) begin
                    count_d = count_inc;
                    if (count_inc == CNT_W'(no_of_digits)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.dout_ready) begin
                    state_d     = ST_IDLE;
                    count_d     = '0;
                    q_d         = '0;
                    qm_d        = '0;
                    digit_err_d = 1'b0;
`ifdef OTF_EARLY_SIGN_EN
                    sign_valid_d = 1'b0;
                    sign_neg_d   = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef OTF_EARLY_SIGN_EN
        // An all-zero word only learns its sign when the word completes.
        if ((state_d == ST_DONE) && (state_q != ST_DONE) && !sign_valid_d) begin
            sign_valid_d = 1'b1;
            sign_neg_d   = 1'b0;
        end
`endif

        din_ready_d  = (state_d != ST_DONE);
        dout_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            q_q          <= '0;
            qm_q         <= '0;
            digit_err_q  <= 1'b0;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
`ifdef OTF_EARLY_SIGN_EN
            sign_valid_q <= 1'b0;
            sign_neg_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            q_q          <= q_d;
            qm_q         <= qm_d;
            digit_err_q  <= digit_err_d;
            din_ready_q  <= din_ready_d;
            dout_valid_q <= dout_valid_d;
`ifdef OTF_EARLY_SIGN_EN
            sign_valid_q <= sign_valid_d;
            sign_neg_q   <= sign_neg_d;
`endif
        end
    end

    assign bus.din_ready  = din_ready_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = q_q;
    assign bus.digit_err  = digit_err_q;
`ifdef OTF_EARLY_SIGN_EN
    assign bus.sign_valid = sign_valid_q;
    assign bus.sign_neg   = sign_neg_q;
`endif
endmodule

// File: tb/tb_otf_sd_converter.sv
// Directed bench for otf_sd_converter (radix 4, 8 digits); sign checks only with OTF_EARLY_SIGN_EN.
module tb_otf_sd_converter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    otf_sd_converter_if #(.no_of_digits(8), .log2_radix(2), .radix_bits(3)) bus ();

    otf_sd_converter #(.no_of_digits(8), .log2_radix(2), .radix_bits(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one digit and hold it until accepted; returns after the accepting edge (+1).
    task automatic send_digit(input logic [2:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.din_valid = 1'b1;
        bus.digit_in  = d;
        while (!bus.din_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("din_ready_timeout", 32'(bus.din_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.dout_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b0;
        chk("post_hs_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("post_hs_din_ready", 32'(bus.din_ready), 32'd1);
        chk("post_hs_digit_err", 32'(bus.digit_err), 32'd0);
    endtask

    initial begin
        logic [16:0] held;
        bus.din_valid  = 1'b0;
        bus.digit_in   = 3'd0;
        bus.dout_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_din_ready", 32'(bus.din_ready), 32'd0);
        chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_digit_err", 32'(bus.digit_err), 32'd0);
`ifdef OTF_EARLY_SIGN_EN
        chk("rst_sign_valid", 32'(bus.sign_valid), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_din_ready", 32'(bus.din_ready), 32'd1);

        // All +3 -> 65535
        for (int i = 0; i < 7; i++) send_digit(3'd3);
        chk("p3_valid_early", 32'(bus.dout_valid), 32'd0);
        send_digit(3'd3);
        chk("p3_valid", 32'(bus.dout_valid), 32'd1);
        chk("p3_dout", 32'(bus.dout), 32'h0FFFF);
        chk("p3_err", 32'(bus.digit_err), 32'd0);
        chk("p3_din_ready", 32'(bus.din_ready), 32'd0);
`ifdef OTF_EARLY_SIGN_EN
        chk("p3_sign_valid", 32'(bus.sign_valid), 32'd1);
        chk("p3_sign_neg", 32'(bus.sign_neg), 32'd0);
`endif
        handshake();

        // All -3 -> -65535
        for (int i = 0; i < 8; i++) send_digit(3'b101);
        chk("m3_valid", 32'(bus.dout_valid), 32'd1);
        chk("m3_dout", 32'(bus.dout), 32'h10001);
`ifdef OTF_EARLY_SIGN_EN
        chk("m3_sign_neg", 32'(bus.sign_neg), 32'd1);
`endif
        handshake();

        // 1 followed by seven -3 -> +1
        send_digit(3'd1);
`ifdef OTF_EARLY_SIGN_EN
        chk("mix_sign_valid", 32'(bus.sign_valid), 32'd1);
        chk("mix_sign_neg", 32'(bus.sign_neg), 32'd0);
`endif
        for (int i = 0; i < 7; i++) send_digit(3'b101);
        chk("mix_dout", 32'(bus.dout), 32'h00001);
        handshake();

        // Seven zeros then -1 -> -1, with backpressure and a stray din_valid in DONE
        for (int i = 0; i < 7; i++) send_digit(3'd0);
`ifdef OTF_EARLY_SIGN_EN
        chk("zm1_sign_pending", 32'(bus.sign_valid), 32'd0);
`endif
        send_digit(3'b111);
        held = bus.dout;
        chk("zm1_dout", 32'(held), 32'h1FFFF);
        @(negedge clk);
        bus.din_valid = 1'b1;
        bus.digit_in  = 3'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_dout", 32'(bus.dout), 32'h1FFFF);
            chk("hold_valid", 32'(bus.dout_valid), 32'd1);
            chk("hold_din_ready", 32'(bus.din_ready), 32'd0);
        end
        bus.din_valid = 1'b0;
        handshake();

        // All +1 directly after; a stray accepted digit would corrupt this
        for (int i = 0; i < 8; i++) send_digit(3'd1);
        chk("p1_dout", 32'(bus.dout), 32'h05555);
        handshake();

        // Reset mid-word, then a clean all +1 word
        for (int i = 0; i < 4; i++) send_digit(3'd3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("midrst_din_ready", 32'(bus.din_ready), 32'd0);
        chk("midrst_dout", 32'(bus.dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) send_digit(3'd1);
        chk("abort_no_output", 32'(bus.dout_valid), 32'd0);
        send_digit(3'd1);
        chk("abort_next_valid", 32'(bus.dout_valid), 32'd1);
        chk("abort_next_dout", 32'(bus.dout), 32'h05555);
        handshake();

        // Illegal digit -4 at position 3: 1,1,-4,1,1,1,1,1 -> Q = 16*4^5 + 341
        send_digit(3'd1);
        send_digit(3'd1);
        chk("err_before", 32'(bus.digit_err), 32'd0);
        send_digit(3'b100);
        chk("err_set", 32'(bus.digit_err), 32'd1);
        for (int i = 0; i < 5; i++) send_digit(3'd1);
        chk("err_sticky", 32'(bus.digit_err), 32'd1);
        chk("err_dout", 32'(bus.dout), 32'h04155);
        handshake();

        // Clean all-zero word
        for (int i = 0; i < 8; i++) send_digit(3'd0);
        chk("zero_valid", 32'(bus.dout_valid), 32'd1);
        chk("zero_dout", 32'(bus.dout), 32'd0);
        chk("zero_err", 32'(bus.digit_err), 32'd0);
`ifdef OTF_EARLY_SIGN_EN
        chk("zero_sign_valid", 32'(bus.sign_valid), 32'd1);
        chk("zero_sign_neg", 32'(bus.sign_neg), 32'd0);
`endif
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
